// File: rtl/gry_ptr_rx.sv
// ---------------------------------------------------------------------------
// gry_ptr_rx
//
// Receives a gray-coded FIFO pointer from a remote clock domain, synchronizes
// it into clk, decodes it to binary and derives FIFO occupancy against the
// local binary pointer. Two sticky error flags report a synchronized gray
// value that moved by more than one bit, and an occupancy beyond the depth.
//
// Parameters
//   P_NUM_BITS    pointer width including the wrap bit; depth = 2**(P_NUM_BITS-1)
//   P_SYNC_STAGES synchronizer length, 2..4
//   P_MODE        0: read side (remote = write pointer)
//                 1: write side (remote = read pointer)
//
// Ports
//   clk            clock, all state on posedge
//   rst            synchronous active-high reset
//   gry_ptr_async  gray pointer from the remote domain (asynchronous)
//   loc_bin_ptr    local binary pointer (next-count value)
//   clr_err        clears err_gray / err_range on the next edge
//   rmt_bin_ptr    synchronized remote pointer in binary (registered)
//   level          occupancy 0..depth (registered, saturating)
//   empty          level == 0 (registered)
//   full           level == depth (registered)
//   err_gray       sticky: multi-bit change seen on the synchronized gray value
//   err_range      sticky: computed occupancy exceeded the depth
// ---------------------------------------------------------------------------
module gry_ptr_rx #(
    parameter int unsigned P_NUM_BITS    = 8,
    parameter int unsigned P_SYNC_STAGES = 2,
    parameter int unsigned P_MODE        = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [P_NUM_BITS-1:0] gry_ptr_async,
    input  logic [P_NUM_BITS-1:0] loc_bin_ptr,
    input  logic                  clr_err,
    output logic [P_NUM_BITS-1:0] rmt_bin_ptr,
    output logic [P_NUM_BITS-1:0] level,
    output logic                  empty,
    output logic                  full,
    output logic                  err_gray,
    output logic                  err_range
);

    localparam int unsigned           LAST  = P_SYNC_STAGES - 1;
    localparam logic [P_NUM_BITS-1:0] DEPTH = P_NUM_BITS'(2 ** (P_NUM_BITS - 1));

    // Synchronizer chain: plain flop-to-flop, nothing between stages.
    logic [P_NUM_BITS-1:0] sync_q [P_SYNC_STAGES];
    logic [P_NUM_BITS-1:0] prev_gry;

    logic [P_NUM_BITS-1:0] gry_last;
    logic [P_NUM_BITS-1:0] gry_delta;
    logic [P_NUM_BITS-1:0] rmt_bin_nxt;
    logic [P_NUM_BITS-1:0] diff;
    logic [P_NUM_BITS-1:0] level_nxt;
    logic                  gray_jump;
    logic                  over_range;

    assign gry_last  = sync_q[LAST];
    assign gry_delta = gry_last ^ prev_gry;

    // Gray decode: bin[j] is the XOR of g[j..MSB], built as the XOR of g
    // shifted right by every distance.
    always_comb begin
        rmt_bin_nxt = gry_last;
        for (int unsigned i = 1; i < P_NUM_BITS; i++) begin
            rmt_bin_nxt = rmt_bin_nxt ^ (gry_last >> i);
        end
    end

    // More than one bit set in the delta: clearing the lowest set bit
    // leaves something behind.
    assign gray_jump = (gry_delta & (gry_delta - P_NUM_BITS'(1))) != '0;

    // Occupancy, modulo 2**P_NUM_BITS, oriented by which side we are on.
    always_comb begin
        if (P_MODE == 0) begin
            diff = rmt_bin_ptr - loc_bin_ptr;
        end else begin
            diff = loc_bin_ptr - rmt_bin_ptr;
        end
        over_range = diff > DEPTH;
        level_nxt  = over_range ? DEPTH : diff;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < P_SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            prev_gry    <= '0;
            rmt_bin_ptr <= '0;
            level       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            err_gray    <= 1'b0;
            err_range   <= 1'b0;
        end else begin
            sync_q[0] <= gry_ptr_async;
            for (int unsigned k = 1; k < P_SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            prev_gry    <= gry_last;
            rmt_bin_ptr <= rmt_bin_nxt;
            level       <= level_nxt;
            empty       <= (level_nxt == '0);
            full        <= (level_nxt == DEPTH);
            // A new error condition overrides a simultaneous clear.
            err_gray    <= gray_jump  | (err_gray  & ~clr_err);
            err_range   <= over_range | (err_range & ~clr_err);
        end
    end

endmodule

// File: doc/gry_ptr_rx.md
GRY_PTR_RX -- requirements
Module: gry_ptr_rx

Interface
REQ-001 Parameter P_NUM_BITS, default 8: pointer width including wrap bit; FIFO depth = 2**(P_NUM_BITS-1).
REQ-002 Parameter P_SYNC_STAGES, default 2, legal range 2..4: number of synchronizer flops.
REQ-003 Parameter P_MODE, default 0: 0 = read side (remote pointer is write pointer); 1 = write side (remote pointer is read pointer).
REQ-004 Port list, one per line: name, direction, width, meaning:
- clk  in  1: single clock; all state on posedge.
- rst  in  1: synchronous, active-high reset.
- gry_ptr_async  in  P_NUM_BITS: gray-coded pointer from the remote clock domain; asynchronous to clk.
- loc_bin_ptr  in  P_NUM_BITS: local binary pointer; the caller drives the next-count value.
- clr_err  in  1: clears the sticky error flags.
- rmt_bin_ptr  out  P_NUM_BITS: synchronized remote pointer, decoded to binary, registered.
- level  out  P_NUM_BITS: registered FIFO occupancy, 0..2**(P_NUM_BITS-1).
- empty  out  1: registered; level == 0.
- full  out  1: registered; level == 2**(P_NUM_BITS-1).
- err_gray  out  1: sticky; the synchronized gray value changed by more than one bit in one cycle.
- err_range  out  1: sticky; the computed occupancy exceeded the depth.

Function
REQ-005 gry_ptr_async SHALL pass through a chain of P_SYNC_STAGES flops, sync[0]..sync[P_SYNC_STAGES-1]; no logic is allowed between stages.
REQ-006 Gray-to-binary decode of the final sync stage: bin[MSB] = g[MSB]; for i < MSB, bin[i] = bin[i+1] XOR g[i]. The result is registered into rmt_bin_ptr.
REQ-007 Latency from a stable change on gry_ptr_async to rmt_bin_ptr SHALL be P_SYNC_STAGES+1 clk edges.
REQ-008 Occupancy diff, computed modulo 2**P_NUM_BITS:
- P_MODE=0: diff = rmt_bin_ptr - loc_bin_ptr.
- P_MODE=1: diff = loc_bin_ptr - rmt_bin_ptr.
REQ-009 level, empty and full SHALL register diff and its flags on the same edge; latency from loc_bin_ptr is 1 edge, and from gry_ptr_async it is P_SYNC_STAGES+2 edges.
REQ-010 If diff > 2**(P_NUM_BITS-1):
- level SHALL saturate to 2**(P_NUM_BITS-1).
- full SHALL be 1 and empty 0.
- err_range SHALL set.
REQ-011 A register prev_gry SHALL hold the previous final-stage value; err_gray SHALL set when popcount(sync[last] XOR prev_gry) > 1.
REQ-012 Wrap of the gray value from MSB-only (e.g. 1000) to 0000 is a single-bit change and SHALL NOT set err_gray.
REQ-013 Error flags remain set until clr_err or rst; clr_err clears both on the next edge.
REQ-014 When clr_err coincides with a new error condition, the set SHALL win.
REQ-015 The block has no handshake; all inputs are sampled every cycle.

Reset
REQ-016 While rst is high at a clk edge, the following SHALL load 0:
- all sync stages and prev_gry;
- rmt_bin_ptr and level;
- full, err_gray and err_range.
empty SHALL load 1.
REQ-017 Reset asserted mid-operation SHALL override every other update in that cycle.
REQ-018 After rst deasserts, the remote value needs P_SYNC_STAGES+1 edges to reach rmt_bin_ptr; the outputs in between SHALL remain the reset values.

Verification (P_NUM_BITS=4, P_SYNC_STAGES=2)
REQ-019 P_MODE=0, loc_bin_ptr=0, gry_ptr_async 0000->0001:
- rmt_bin_ptr=1 after 3 edges;
- level=1 and empty=0 after 4 edges.
REQ-020 P_MODE=1, remote gray 0000 held, loc_bin_ptr 0111->1000: full=1, level=8 one edge after the change; no error.
REQ-021 P_MODE=0, loc_bin_ptr=1111, gray 1000->0000 (bin 15->0):
- rmt_bin_ptr=0;
- level=1;
- err_gray stays 0.
REQ-022 Gray 0000->0011:
- err_gray=1 three edges later and held;
- clr_err pulsed for one cycle -> 0 next edge;
- clr_err together with a fresh two-bit jump -> stays 1.
REQ-023 P_MODE=0, rmt_bin_ptr=0, loc_bin_ptr=0111 (diff=9): level=8, full=1, err_range=1.
REQ-024 rst pulsed while level=5 and err_gray=1 -> next edge: level=0, empty=1, full=0, both errors 0, rmt_bin_ptr=0.
